// File: rtl/edge_sequencer.sv
// Walks the edge table each frame and issues one draw_line job per edge, forwarding pixels to a valid/ready sink.
// Optional build macro EDGE_SEQ_SKIP_DEGEN_EN skips edges whose two endpoints are the same vertex.
module edge_sequencer #(
    parameter int XY_BITW   = 16,
    parameter int NUM_VERT  = 8,
    parameter int VIDX_BITW = 3,
    parameter int NUM_EDGE  = 12,
    parameter int EIDX_BITW = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 vert_we,
    input  logic [VIDX_BITW-1:0] vert_addr,
    input  logic [XY_BITW-1:0]   vert_x,
    input  logic [XY_BITW-1:0]   vert_y,
    input  logic                 edge_we,
    input  logic [EIDX_BITW-1:0] edge_addr,
    input  logic [VIDX_BITW-1:0] edge_a,
    input  logic [VIDX_BITW-1:0] edge_b,
    input  logic [EIDX_BITW-1:0] edge_count,
    input  logic                 frame_start,
    output logic                 busy,
    output logic                 frame_done,
    output logic [EIDX_BITW-1:0] cur_edge,
    output logic                 dl_start,
    output logic                 dl_oe,
    output logic [XY_BITW-1:0]   dl_x0,
    output logic [XY_BITW-1:0]   dl_y0,
    output logic [XY_BITW-1:0]   dl_x1,
    output logic [XY_BITW-1:0]   dl_y1,
    input  logic [XY_BITW-1:0]   dl_x,
    input  logic [XY_BITW-1:0]   dl_y,
    input  logic                 dl_drawing,
    input  logic                 dl_done,
    output logic                 pix_valid,
    input  logic                 pix_ready,
    output logic [XY_BITW-1:0]   pix_x,
    output logic [XY_BITW-1:0]   pix_y
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_START, S_WAIT, S_NEXT, S_DONE
    } state_t;

    localparam logic [EIDX_BITW-1:0] EDGE_MAX = EIDX_BITW'(NUM_EDGE);
    localparam logic [EIDX_BITW-1:0] ONE      = EIDX_BITW'(1);

    state_t state, state_nxt;

    logic [XY_BITW-1:0]   vx_tab [NUM_VERT];
    logic [XY_BITW-1:0]   vy_tab [NUM_VERT];
    logic [VIDX_BITW-1:0] ea_tab [NUM_EDGE];
    logic [VIDX_BITW-1:0] eb_tab [NUM_EDGE];

    logic [VIDX_BITW-1:0] ea_r, eb_r;
    logic [VIDX_BITW-1:0] va_idx, vb_idx;
    logic [EIDX_BITW-1:0] count_r;
    logic [EIDX_BITW-1:0] count_in;
    logic                 last_edge;
    logic                 skip;

    assign count_in  = (edge_count > EDGE_MAX) ? EDGE_MAX : edge_count;
    assign last_edge = (cur_edge == count_r - ONE);
    // Indices beyond the populated vertex range fall back to vertex 0.
    assign va_idx    = (32'(ea_r) < NUM_VERT) ? ea_r : '0;
    assign vb_idx    = (32'(eb_r) < NUM_VERT) ? eb_r : '0;

`ifdef EDGE_SEQ_SKIP_DEGEN_EN
    assign skip = (ea_r == eb_r);
`else
    assign skip = 1'b0;
`endif

    assign pix_valid = dl_drawing;
    assign pix_x     = dl_x;
    assign pix_y     = dl_y;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        busy       = (state != S_IDLE);
        dl_start   = 1'b0;
        dl_oe      = 1'b0;
        frame_done = 1'b0;
        case (state)
            S_IDLE:  if (frame_start) state_nxt = (count_in != '0) ? S_FETCH : S_DONE;
            S_FETCH: state_nxt = S_LOAD;
            S_LOAD:  state_nxt = skip ? S_NEXT : S_START;
            S_START: begin
                dl_start  = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                dl_oe = pix_ready;
                if (dl_done) state_nxt = S_NEXT;
            end
            S_NEXT:  state_nxt = last_edge ? S_DONE : S_FETCH;
            S_DONE: begin
                frame_done = 1'b1;
                state_nxt  = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Tables are frozen while a frame is in flight so every edge sees one consistent snapshot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_VERT; i++) begin
                vx_tab[i] <= '0;
                vy_tab[i] <= '0;
            end
            for (int i = 0; i < NUM_EDGE; i++) begin
                ea_tab[i] <= '0;
                eb_tab[i] <= '0;
            end
        end else if (state == S_IDLE) begin
            if (vert_we && (32'(vert_addr) < NUM_VERT)) begin
                vx_tab[vert_addr] <= vert_x;
                vy_tab[vert_addr] <= vert_y;
            end
            if (edge_we && (edge_addr < EDGE_MAX)) begin
                ea_tab[edge_addr] <= edge_a;
                eb_tab[edge_addr] <= edge_b;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_edge <= '0;
            count_r  <= '0;
            ea_r     <= '0;
            eb_r     <= '0;
            dl_x0    <= '0;
            dl_y0    <= '0;
            dl_x1    <= '0;
            dl_y1    <= '0;
        end else begin
            case (state)
                S_IDLE: if (frame_start) begin
                    count_r  <= count_in;
                    cur_edge <= '0;
                end
                S_FETCH: begin
                    ea_r <= ea_tab[cur_edge];
                    eb_r <= eb_tab[cur_edge];
                end
                S_LOAD: if (!skip) begin
                    dl_x0 <= vx_tab[va_idx];
                    dl_y0 <= vy_tab[va_idx];
                    dl_x1 <= vx_tab[vb_idx];
                    dl_y1 <= vy_tab[vb_idx];
                end
                S_NEXT: if (!last_edge) cur_edge <= cur_edge + ONE;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_edge_sequencer.sv
// Bench for edge_sequencer: behavioural draw_line stub, monitor queues and a table-level reference model.
module tb_edge_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        vert_we;
    logic [2:0]  vert_addr;
    logic [15:0] vert_x, vert_y;
    logic        edge_we;
    logic [3:0]  edge_addr;
    logic [2:0]  edge_a, edge_b;
    logic [3:0]  edge_count;
    logic        frame_start;
    logic        busy, frame_done;
    logic [3:0]  cur_edge;
    logic        dl_start, dl_oe;
    logic [15:0] dl_x0, dl_y0, dl_x1, dl_y1;
    logic [15:0] dl_x, dl_y;
    logic        dl_drawing, dl_done;
    logic        pix_valid, pix_ready;
    logic [15:0] pix_x, pix_y;

    edge_sequencer dut (
        .clk(clk), .rst(rst),
        .vert_we(vert_we), .vert_addr(vert_addr), .vert_x(vert_x), .vert_y(vert_y),
        .edge_we(edge_we), .edge_addr(edge_addr), .edge_a(edge_a), .edge_b(edge_b),
        .edge_count(edge_count), .frame_start(frame_start),
        .busy(busy), .frame_done(frame_done), .cur_edge(cur_edge),
        .dl_start(dl_start), .dl_oe(dl_oe),
        .dl_x0(dl_x0), .dl_y0(dl_y0), .dl_x1(dl_x1), .dl_y1(dl_y1),
        .dl_x(dl_x), .dl_y(dl_y), .dl_drawing(dl_drawing), .dl_done(dl_done),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference tables as the bench believes them to be.
    int mvx [8];
    int mvy [8];
    int mea [12];
    int meb [12];

    // Monitor results.
    logic [63:0] st_q [$];
    int          ce_q [$];
    logic [31:0] px_q [$];
    logic [31:0] ref_q [$];
    int          fd_cnt, oe_chk, oe_bad, stall_cnt;
    bit          run_over;

    // draw_line stand-in: Bresenham walk that holds its pixel while oe is low.
    int  cx, cy, tx, ty, sx, sy, ddx, ddy, err, e2, px0, py0, px1, py1;
    bit  active, s_st, s_oe;
    initial begin
        dl_drawing = 1'b0; dl_done = 1'b0; dl_x = '0; dl_y = '0; active = 0;
        forever begin
            @(negedge clk);
            s_st = dl_start; s_oe = dl_oe;
            px0 = int'(dl_x0); py0 = int'(dl_y0); px1 = int'(dl_x1); py1 = int'(dl_y1);
            @(posedge clk); #1;
            dl_done = 1'b0;
            if (rst) begin
                active = 0; dl_drawing = 1'b0;
            end else if (active) begin
                if (s_oe) begin
                    if (cx == tx && cy == ty) begin
                        active = 0; dl_drawing = 1'b0; dl_done = 1'b1;
                    end else begin
                        e2 = 2 * err;
                        if (e2 >= ddy) begin err += ddy; cx += sx; end
                        if (e2 <= ddx) begin err += ddx; cy += sy; end
                        dl_x = 16'(cx); dl_y = 16'(cy);
                    end
                end
            end else if (s_st) begin
                cx = px0; cy = py0; tx = px1; ty = py1;
                ddx = (tx > cx) ? tx - cx : cx - tx;
                ddy = -((ty > cy) ? ty - cy : cy - ty);
                sx = (cx < tx) ? 1 : -1;
                sy = (cy < ty) ? 1 : -1;
                err = ddx + ddy;
                dl_x = 16'(cx); dl_y = 16'(cy);
                dl_drawing = 1'b1; active = 1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (dl_start) begin
                    st_q.push_back({dl_x0, dl_y0, dl_x1, dl_y1});
                    ce_q.push_back(int'(cur_edge));
                end
                if (pix_valid && pix_ready) px_q.push_back({pix_x, pix_y});
                if (frame_done) fd_cnt++;
                if (pix_valid) begin
                    oe_chk++;
                    if (dl_oe !== pix_ready) oe_bad++;
                    if (!dl_oe) stall_cnt++;
                end
            end
        end
    end

    function automatic int line_len(int x0, int y0, int x1, int y1);
        int dx = (x1 > x0) ? x1 - x0 : x0 - x1;
        int dy = (y1 > y0) ? y1 - y0 : y0 - y1;
        return ((dx > dy) ? dx : dy) + 1;
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_mon();
        st_q.delete(); ce_q.delete(); px_q.delete();
        fd_cnt = 0; oe_chk = 0; oe_bad = 0; stall_cnt = 0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 8; i++) begin mvx[i] = 0; mvy[i] = 0; end
        for (int i = 0; i < 12; i++) begin mea[i] = 0; meb[i] = 0; end
    endtask

    task automatic write_vert(input int i, input int x, input int y);
        vert_we = 1'b1; vert_addr = 3'(i); vert_x = 16'(x); vert_y = 16'(y);
        tick();
        vert_we = 1'b0;
        mvx[i] = x; mvy[i] = y;
    endtask

    task automatic write_edge(input int i, input int a, input int b);
        edge_we = 1'b1; edge_addr = 4'(i); edge_a = 3'(a); edge_b = 3'(b);
        tick();
        edge_we = 1'b0;
        mea[i] = a; meb[i] = b;
    endtask

    task automatic run_frame(input int cnt, input string name);
        int k = 0;
        clear_mon();
        run_over = 0;
        edge_count = 4'(cnt); frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        while (fd_cnt == 0 && k < 5000) begin tick(); k++; end
        tick(); tick();
        run_over = 1;
        total++;
        if (fd_cnt == 0) begin
            bad++; $display("FAIL %s timeout: frame_done never seen after %0d cycles", name, k);
        end
    endtask

    task automatic check_frame(input int cnt, input string name);
        int n = (cnt > 12) ? 12 : cnt;
        logic [63:0] exp_st [$];
        int exp_ce [$];
        int pix_sum = 0;
        for (int i = 0; i < n; i++) begin
            int a = mea[i];
            int b = meb[i];
`ifdef EDGE_SEQ_SKIP_DEGEN_EN
            if (a == b) continue;
`endif
            exp_st.push_back({16'(mvx[a]), 16'(mvy[a]), 16'(mvx[b]), 16'(mvy[b])});
            exp_ce.push_back(i);
            pix_sum += line_len(mvx[a], mvy[a], mvx[b], mvy[b]);
        end
        total++;
        if (st_q.size() !== exp_st.size()) begin
            bad++; $display("FAIL %s start_count: got %0d want %0d", name, st_q.size(), exp_st.size());
        end else begin
            for (int i = 0; i < exp_st.size(); i++) begin
                total++;
                if (st_q[i] !== exp_st[i] || ce_q[i] !== exp_ce[i]) begin
                    bad++;
                    $display("FAIL %s job%0d: got ends=%h edge=%0d want ends=%h edge=%0d",
                             name, i, st_q[i], ce_q[i], exp_st[i], exp_ce[i]);
                end
            end
        end
        total++;
        if (px_q.size() !== pix_sum) begin
            bad++; $display("FAIL %s pixel_count: got %0d want %0d", name, px_q.size(), pix_sum);
        end
        total++;
        if (fd_cnt !== 1) begin
            bad++; $display("FAIL %s frame_done_count: got %0d want 1", name, fd_cnt);
        end
        total++;
        if (int'(cur_edge) !== ((n > 0) ? n - 1 : 0) || busy !== 1'b0) begin
            bad++; $display("FAIL %s final: got cur_edge=%0d busy=%b want cur_edge=%0d busy=0",
                            name, cur_edge, busy, (n > 0) ? n - 1 : 0);
        end
    endtask

    task automatic load_cube();
        int ca [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
        int cb [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
        for (int i = 0; i < 8; i++) write_vert(i, $urandom_range(0, 60), $urandom_range(0, 60));
        for (int i = 0; i < 12; i++) write_edge(i, ca[i], cb[i]);
    endtask

    task automatic test_reset();
        rst = 1'b1; vert_we = 0; vert_addr = 0; vert_x = 0; vert_y = 0;
        edge_we = 0; edge_addr = 0; edge_a = 0; edge_b = 0; edge_count = 0;
        frame_start = 0; pix_ready = 1'b1;
        clear_model();
        repeat (3) tick();
        total++;
        if ({busy, frame_done, dl_start, dl_oe, pix_valid, cur_edge, dl_x0, dl_y0, dl_x1, dl_y1} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got busy=%b fd=%b st=%b oe=%b pv=%b ce=%0d ends=%h%h%h%h want all 0",
                     busy, frame_done, dl_start, dl_oe, pix_valid, cur_edge, dl_x0, dl_y0, dl_x1, dl_y1);
        end
        rst = 1'b0;
        tick();
        total++;
        if (busy !== 1'b0 || dl_oe !== 1'b0) begin
            bad++; $display("FAIL reset_idle: got busy=%b oe=%b want 0 0", busy, dl_oe);
        end
    endtask

    task automatic test_single_edge();
        int k = 0;
        write_vert(0, 10, 10);
        write_edge(0, 0, 1);
        clear_mon();
        // vertex 1 is written in the same cycle as frame_start and must still be used
        vert_we = 1'b1; vert_addr = 3'd1; vert_x = 16'd10; vert_y = 16'd0;
        mvx[1] = 10; mvy[1] = 0;
        edge_count = 4'd1; frame_start = 1'b1;
        tick();
        vert_we = 1'b0; frame_start = 1'b0;
        total++;
        if (busy !== 1'b1 || dl_start !== 1'b0) begin
            bad++; $display("FAIL single_busy_rise: got busy=%b st=%b want 1 0", busy, dl_start);
        end
        tick();
        total++;
        if (dl_start !== 1'b0) begin
            bad++; $display("FAIL single_early_start: got %b want 0", dl_start);
        end
        tick();
        total++;
        if (dl_start !== 1'b1 || {dl_x0, dl_y0, dl_x1, dl_y1} !== {16'd10, 16'd10, 16'd10, 16'd0}) begin
            bad++; $display("FAIL single_start: got st=%b ends=(%0d,%0d)->(%0d,%0d) want 1 (10,10)->(10,0)",
                            dl_start, dl_x0, dl_y0, dl_x1, dl_y1);
        end
        tick();
        total++;
        if (dl_start !== 1'b0) begin
            bad++; $display("FAIL single_start_width: got %b want 0", dl_start);
        end
        while (fd_cnt == 0 && k < 200) begin tick(); k++; end
        tick();
        total++;
        if (px_q.size() !== 11) begin
            bad++; $display("FAIL single_pix_count: got %0d want 11", px_q.size());
        end else begin
            for (int i = 0; i < 11; i++) begin
                logic [31:0] want = {16'd10, 16'(10 - i)};
                total++;
                if (px_q[i] !== want) begin
                    bad++; $display("FAIL single_pix%0d: got %h want %h", i, px_q[i], want);
                end
            end
        end
        total++;
        if (fd_cnt !== 1 || busy !== 1'b0 || st_q.size() !== 1) begin
            bad++; $display("FAIL single_end: got fd=%0d busy=%b starts=%0d want 1 0 1", fd_cnt, busy, st_q.size());
        end
    endtask

    task automatic test_cube();
        load_cube();
        run_frame(12, "cube");
        check_frame(12, "cube");
    endtask

    task automatic test_count_limits();
        clear_mon();
        edge_count = 4'd0; frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        total++;
        if (frame_done !== 1'b1) begin
            bad++; $display("FAIL zero_done: got frame_done=%b want 1", frame_done);
        end
        tick();
        total++;
        if (frame_done !== 1'b0 || busy !== 1'b0 || st_q.size() !== 0 || fd_cnt !== 1) begin
            bad++; $display("FAIL zero_after: got fd=%b busy=%b starts=%0d pulses=%0d want 0 0 0 1",
                            frame_done, busy, st_q.size(), fd_cnt);
        end
        run_frame(15, "clamp15");
        check_frame(15, "clamp15");
    endtask

    task automatic test_backpressure();
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        write_vert(0, 5, 7);
        write_vert(1, 5 + $urandom_range(20, 40), 7 + $urandom_range(0, 15));
        write_edge(0, 0, 1);
        pix_ready = 1'b1;
        run_frame(1, "bp_ref");
        ref_q = px_q;
        fork
            run_frame(1, "bp_stall");
            begin
                int k = 0;
                while (!run_over) begin
                    pix_ready = pat[k % 4];
                    k++;
                    tick();
                end
            end
        join
        pix_ready = 1'b1;
        total++;
        if (px_q.size() !== ref_q.size()) begin
            bad++; $display("FAIL bp_count: got %0d want %0d", px_q.size(), ref_q.size());
        end else begin
            int diffs = 0;
            foreach (ref_q[i]) if (px_q[i] !== ref_q[i]) diffs++;
            total++;
            if (diffs !== 0) begin
                bad++; $display("FAIL bp_sequence: got %0d differing pixels want 0", diffs);
            end
        end
        total++;
        if (oe_bad !== 0 || stall_cnt == 0) begin
            bad++; $display("FAIL bp_oe: got oe_mismatch=%0d stall_cycles=%0d want 0 and >0", oe_bad, stall_cnt);
        end
    endtask

    task automatic test_busy_ignore();
        int k = 0;
        load_cube();
        clear_mon();
        run_over = 0;
        edge_count = 4'd12; frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        while (st_q.size() < 3 && k < 3000) begin tick(); k++; end
        vert_we = 1'b1; vert_addr = 3'd0; vert_x = 16'd999; vert_y = 16'd999;
        edge_we = 1'b1; edge_addr = 4'd0; edge_a = 3'd7; edge_b = 3'd7;
        edge_count = 4'd1; frame_start = 1'b1;
        tick();
        vert_we = 1'b0; edge_we = 1'b0; frame_start = 1'b0;
        k = 0;
        while (fd_cnt == 0 && k < 5000) begin tick(); k++; end
        repeat (5) tick();
        check_frame(12, "busy_ignore");
        run_frame(12, "second_frame");
        check_frame(12, "second_frame");
    endtask

    task automatic test_reset_midframe();
        int k = 0;
        load_cube();
        clear_mon();
        edge_count = 4'd12; frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        while (st_q.size() < 6 && k < 3000) begin tick(); k++; end
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        total++;
        if ({busy, frame_done, dl_start, dl_oe, cur_edge, dl_x0, dl_y0, dl_x1, dl_y1} !== '0) begin
            bad++; $display("FAIL midreset_outputs: got busy=%b fd=%b st=%b oe=%b ce=%0d want all 0",
                            busy, frame_done, dl_start, dl_oe, cur_edge);
        end
        tick(); tick();
        rst = 1'b0;
        clear_model();
        repeat (4) tick();
        total++;
        if (fd_cnt !== 0 || busy !== 1'b0) begin
            bad++; $display("FAIL midreset_no_done: got fd=%0d busy=%b want 0 0", fd_cnt, busy);
        end
        run_frame(12, "after_reset");
        check_frame(12, "after_reset");
    endtask

    task automatic test_degen();
        for (int i = 0; i < 8; i++) write_vert(i, $urandom_range(0, 30), $urandom_range(0, 30));
        write_edge(0, 1, 2);
        write_edge(1, 3, 3);
        write_edge(2, 4, 5);
        run_frame(3, "degen");
        check_frame(3, "degen");
    endtask

    initial begin
        test_reset();
        test_single_edge();
        test_cube();
        test_count_limits();
        test_backpressure();
        test_busy_ignore();
        test_reset_midframe();
        test_degen();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
